pwm_capture: RTL and testbench
==============================

# pwm_capture

Measuring receiver for the single-wire PWM outputs our pattern generators drive (fixed 64-cycle-frame `Pulse` lines such as the solid-square axis drivers). It synchronises an incoming pulse line into `sysclk` and measures each rising-edge-to-rising-edge period and the high time within it. It reports one measurement per period with a single-cycle strobe, or a static-level report when no edges arrive within a timeout. It sits on the loopback or sense side of a generator, for self-test and closed-loop checking.

## Interface
- `CNT_W`, 8: width of the period and high-time counters and outputs.
- `TIMEOUT`, 200: cycles without a rising edge before a static report. Legal range is 2..2^CNT_W-1.

- `sysclk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `Enable` in 1: 1 = measure; 0 = clear measurement state.
- `Pulse_In` in 1: asynchronous PWM input.
- `Period` out CNT_W: cycles from one rise to the next; 0 on a static report.
- `High_Time` out CNT_W: high cycles within that period; 0 on a static report.
- `Static` out 1: 1 = last report was a timeout.
- `Level` out 1: synchronised line level captured at the timeout; meaningful only when `Static`=1.
- `Meas_Valid` out 1: single-cycle strobe; the outputs above update on the same edge.

## Operation
- **Synchroniser:** `s0 <= Pulse_In`, `s1 <= s0`, `s_prev <= s1`. `rise = s1 & ~s_prev`. Only `s1` is used downstream.
- **Internal state:**
  - `period_cnt` and `high_cnt` (CNT_W bits).
  - `armed`: a previous rise has been seen.
  - `timed_out`: a static report is already issued.
- **Per-edge priority**, when `rst_n`=1 and `Enable`=1:
  1. **rise:**
     - If `armed`: `Period <= period_cnt`, `High_Time <= high_cnt`, `Static <= 0`, `Meas_Valid <= 1`.
     - Always: `period_cnt <= 1`, `high_cnt <= 1`, `armed <= 1`, `timed_out <= 0`.
  2. **no rise, `period_cnt == TIMEOUT`, `timed_out == 0`:**
     - Outputs: `Period <= 0`, `High_Time <= 0`, `Static <= 1`, `Level <= s1`, `Meas_Valid <= 1`.
     - State: `armed <= 0`, `timed_out <= 1`; counters hold.
  3. **otherwise:**
     - `period_cnt <= period_cnt + 1`, saturating at `TIMEOUT`.
     - `high_cnt <= high_cnt + s1`, saturating at `TIMEOUT`.
     - `Meas_Valid <= 0`.
- **First rise** after reset, after a timeout or after `Enable` rises: arms only, no strobe.
- **Rise with `period_cnt == TIMEOUT`:** the rise wins and reports `Period` = `TIMEOUT`.
- **Static line:** one static report per episode. Further strobes occur only after a rise followed by a complete period.
- **`Enable` = 0:**
  - Counters cleared to 0; `armed`, `timed_out`, `Meas_Valid` cleared to 0.
  - `Period`, `High_Time`, `Static`, `Level` hold their values.
  - The synchroniser keeps running.
- **Reset values:**
  - `Period`, `High_Time`, `Static`, `Level`, `Meas_Valid` all 0.
  - `s0`, `s1`, `s_prev`, counters, `armed`, `timed_out` all 0.
  - Applies on any edge with `rst_n`=0, including mid-period; the partial period is discarded.

## Timing
- **Input to rise:** `Pulse_In` sampled high at edge k sets `s1` at edge k+1. `rise` is true in the cycle after edge k+1. The measurement strobe is registered at edge k+2.
- **Strobe position:** `Meas_Valid` is high for exactly one cycle, two edges after the sampling edge of the closing rise.
- **Minimum period:** 2 cycles; consecutive strobes can then be 2 cycles apart.
- **Timeout, no edges after reset:** the static strobe occurs at edge TIMEOUT+1 after reset release.
  - `period_cnt` reaches `TIMEOUT` after `TIMEOUT` increments.
  - The following edge issues the report.
- **Timeout after a rise:** the static strobe occurs `TIMEOUT` edges after the rise edge.
- **Accuracy:** `Period` and `High_Time` are exact in `sysclk` cycles for inputs already synchronous to `sysclk`. For asynchronous inputs each may differ by ±1 cycle.

## Test plan
- **Basic square wave:** 64-cycle period, 32 high / 32 low, synchronous, 4 periods.
  - First strobe 64 cycles after the first rise.
  - Each strobe reports `Period`=64, `High_Time`=32, `Static`=0.
  - Strobes are 64 cycles apart.
- **Extreme duty cycles:** 64-cycle frame with 1 high / 63 low, then 63 high / 1 low.
  - Strobes report `High_Time`=1, then 63; `Period`=64 throughout.
- **Static lines:**
  - Input held high for 300 cycles after one period: exactly one static strobe, `Static`=1, `Level`=1, `Period`=0, `High_Time`=0.
  - Input held low from reset: static strobe at cycle 201 with `Level`=0, then no further strobes.
  - Subsequent 64/32 toggling: the first rise produces no strobe; the second rise reports 64/32.
- **Minimum period:** period 2 (1 high / 1 low).
  - `Meas_Valid` alternates 1/0.
  - Every strobe reports `Period`=2, `High_Time`=1.
- **Enable and reset mid-period:**
  - Drop `Enable` for 5 cycles mid-period: outputs hold the last 64/32 values, `Meas_Valid`=0. After re-enable, the first rise produces no strobe and the next rise reports 64/32.
  - Assert `rst_n`=0 for 1 cycle mid-period: all outputs read 0 on the next edge.
- **Timeout boundary:** `TIMEOUT`=64 with a 64/32 input.
  - Rises land exactly at `period_cnt`=64, so normal strobes report 64/32 with no static report.
  - A 65-cycle period produces a static strobe instead.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures rise-to-rise period and high time of an asynchronous
// PWM line in sysclk cycles, with a single-cycle result strobe and a one-shot
// static-level report when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             Enable,
  input  logic             Pulse_In,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] High_Time,
  output logic             Static,
  output logic             Level,
  output logic             Meas_Valid
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

  logic             r_s0;
  logic             r_s1;
  logic             r_s_prev;
  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic             r_armed;
  logic             r_timed_out;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_static;
  logic             r_level;
  logic             r_meas_valid;

  logic             w_rise;
  logic             w_at_timeout;
  logic [CNT_W-1:0] w_period_inc;
  logic [CNT_W-1:0] w_high_inc;

  assign w_rise       = r_s1 & ~r_s_prev;
  assign w_at_timeout = (r_period_cnt == LP_TIMEOUT);

  // Both counters stop at TIMEOUT so a dead line never wraps into a bogus value.
  assign w_period_inc = w_at_timeout ? r_period_cnt : r_period_cnt + 1'b1;
  assign w_high_inc   = (r_high_cnt == LP_TIMEOUT) ? r_high_cnt
                      : r_high_cnt + {{(CNT_W-1){1'b0}}, r_s1};

  // Two-flop synchroniser plus edge-history flop; runs regardless of Enable.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_s_prev <= 1'b0;
    end else begin
      r_s0     <= Pulse_In;
      r_s1     <= r_s0;
      r_s_prev <= r_s1;
    end
  end

  // Measurement: a rise closes a period (reporting only if armed), a timeout
  // issues one static report per episode, otherwise the counters run.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_armed      <= 1'b0;
      r_timed_out  <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_static     <= 1'b0;
      r_level      <= 1'b0;
      r_meas_valid <= 1'b0;
    end else if (!Enable) begin
      // Reported values are kept so software can still read the last result.
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_armed      <= 1'b0;
      r_timed_out  <= 1'b0;
      r_meas_valid <= 1'b0;
    end else if (w_rise) begin
      if (r_armed) begin
        r_period    <= r_period_cnt;
        r_high_time <= r_high_cnt;
        r_static    <= 1'b0;
      end
      r_meas_valid <= r_armed;
      r_period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_high_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_armed      <= 1'b1;
      r_timed_out  <= 1'b0;
    end else if (w_at_timeout && !r_timed_out) begin
      r_period     <= '0;
      r_high_time  <= '0;
      r_static     <= 1'b1;
      r_level      <= r_s1;
      r_meas_valid <= 1'b1;
      r_armed      <= 1'b0;
      r_timed_out  <= 1'b1;
    end else begin
      r_period_cnt <= w_period_inc;
      r_high_cnt   <= w_high_inc;
      r_meas_valid <= 1'b0;
    end
  end

  assign Period     = r_period;
  assign High_Time  = r_high_time;
  assign Static     = r_static;
  assign Level      = r_level;
  assign Meas_Valid = r_meas_valid;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: one instance with the default timeout and
// one with TIMEOUT=64 share the same stimulus.
module tb_pwm_capture;

  logic       sysclk;
  logic       rst_n;
  logic       enable;
  logic       pulse;

  logic [7:0] a_period, a_high;
  logic       a_static, a_level, a_mv;
  logic [7:0] b_period, b_high;
  logic       b_static, b_level, b_mv;

  int total = 0;
  int bad   = 0;

  int         q_idx[$];
  logic [7:0] q_per[$];
  logic [7:0] q_hi[$];
  logic       q_st[$];
  logic       q_lv[$];

  pwm_capture #(.CNT_W(8), .TIMEOUT(200)) dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .Enable(enable), .Pulse_In(pulse),
    .Period(a_period), .High_Time(a_high), .Static(a_static),
    .Level(a_level), .Meas_Valid(a_mv)
  );

  pwm_capture #(.CNT_W(8), .TIMEOUT(64)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .Enable(enable), .Pulse_In(pulse),
    .Period(b_period), .High_Time(b_high), .Static(b_static),
    .Level(b_level), .Meas_Valid(b_mv)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // One clock: input presented after the edge, outputs sampled 1 ns after the next edge.
  task automatic cyc(input logic p);
    pulse = p;
    @(posedge sysclk);
    #1;
  endtask

  // Drive nfr frames of (per, hi) followed by tail cycles at tail_lvl,
  // logging every strobe of the selected instance with its call index.
  task automatic drive_frames(input int per, input int hi, input int nfr,
                              input int tail, input logic tail_lvl, input bit sel);
    int n = 0;
    q_idx.delete(); q_per.delete(); q_hi.delete(); q_st.delete(); q_lv.delete();
    for (int f = 0; f < nfr; f++) begin
      for (int j = 0; j < per; j++) begin
        cyc(logic'(j < hi));
        if (sel ? b_mv : a_mv) begin
          q_idx.push_back(n);
          q_per.push_back(sel ? b_period : a_period);
          q_hi.push_back(sel ? b_high : a_high);
          q_st.push_back(sel ? b_static : a_static);
          q_lv.push_back(sel ? b_level : a_level);
        end
        n++;
      end
    end
    for (int t = 0; t < tail; t++) begin
      cyc(tail_lvl);
      if (sel ? b_mv : a_mv) begin
        q_idx.push_back(n);
        q_per.push_back(sel ? b_period : a_period);
        q_hi.push_back(sel ? b_high : a_high);
        q_st.push_back(sel ? b_static : a_static);
        q_lv.push_back(sel ? b_level : a_level);
      end
      n++;
    end
  endtask

  // Disarm both instances with a short Enable drop and a low line.
  task automatic reset_meas();
    enable = 1'b0;
    repeat (3) cyc(1'b0);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) cyc(1'b0);
    total++; if (a_period !== 8'd0) begin bad++; $display("FAIL rst_period got=%0d exp=0", a_period); end
    total++; if (a_high !== 8'd0) begin bad++; $display("FAIL rst_high got=%0d exp=0", a_high); end
    total++; if (a_static !== 1'b0) begin bad++; $display("FAIL rst_static got=%b exp=0", a_static); end
    total++; if (a_level !== 1'b0) begin bad++; $display("FAIL rst_level got=%b exp=0", a_level); end
    total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a_mv); end
  endtask

  task automatic test_static_low();
    rst_n = 1'b1;
    drive_frames(1, 0, 0, 260, 1'b0, 1'b0);
    total++; if (q_idx.size() != 1) begin bad++; $display("FAIL stlow_count got=%0d exp=1", q_idx.size()); end
    if (q_idx.size() >= 1) begin
      total++; if (q_idx[0] != 200) begin bad++; $display("FAIL stlow_time got=%0d exp=200", q_idx[0]); end
      total++; if (q_st[0] !== 1'b1 || q_lv[0] !== 1'b0 || q_per[0] !== 8'd0 || q_hi[0] !== 8'd0) begin
        bad++; $display("FAIL stlow_vals got st=%b lv=%b per=%0d hi=%0d exp st=1 lv=0 per=0 hi=0",
                        q_st[0], q_lv[0], q_per[0], q_hi[0]);
      end
    end
  endtask

  task automatic test_square_after_static();
    drive_frames(64, 32, 5, 10, 1'b0, 1'b0);
    total++; if (q_idx.size() != 4) begin bad++; $display("FAIL sq_count got=%0d exp=4", q_idx.size()); end
    total++; if (q_idx.size() < 1 || q_idx[0] != 66) begin
      bad++; $display("FAIL sq_first got=%0d exp=66", (q_idx.size() > 0) ? q_idx[0] : -1);
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_per[i] !== 8'd64 || q_hi[i] !== 8'd32 || q_st[i] !== 1'b0) begin
        bad++; $display("FAIL sq_vals[%0d] got per=%0d hi=%0d st=%b exp 64/32/0", i, q_per[i], q_hi[i], q_st[i]);
      end
      if (i > 0) begin
        total++;
        if (q_idx[i] - q_idx[i-1] != 64) begin
          bad++; $display("FAIL sq_spacing[%0d] got=%0d exp=64", i, q_idx[i] - q_idx[i-1]);
        end
      end
    end
  endtask

  task automatic test_duty_extremes();
    reset_meas();
    drive_frames(64, 1, 4, 0, 1'b0, 1'b0);
    total++; if (q_idx.size() != 3) begin bad++; $display("FAIL duty1_count got=%0d exp=3", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_per[i] !== 8'd64 || q_hi[i] !== 8'd1) begin
        bad++; $display("FAIL duty1_vals[%0d] got per=%0d hi=%0d exp 64/1", i, q_per[i], q_hi[i]);
      end
    end
    reset_meas();
    drive_frames(64, 63, 4, 0, 1'b0, 1'b0);
    total++; if (q_idx.size() != 3) begin bad++; $display("FAIL duty63_count got=%0d exp=3", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_per[i] !== 8'd64 || q_hi[i] !== 8'd63) begin
        bad++; $display("FAIL duty63_vals[%0d] got per=%0d hi=%0d exp 64/63", i, q_per[i], q_hi[i]);
      end
    end
  endtask

  task automatic test_static_high();
    reset_meas();
    drive_frames(64, 32, 1, 300, 1'b1, 1'b0);
    total++; if (q_idx.size() != 2) begin bad++; $display("FAIL sthigh_count got=%0d exp=2", q_idx.size()); end
    if (q_idx.size() == 2) begin
      total++; if (q_idx[0] != 66 || q_per[0] !== 8'd64 || q_hi[0] !== 8'd32) begin
        bad++; $display("FAIL sthigh_meas got idx=%0d per=%0d hi=%0d exp 66/64/32", q_idx[0], q_per[0], q_hi[0]);
      end
      total++; if (q_idx[1] != 266) begin bad++; $display("FAIL sthigh_time got=%0d exp=266", q_idx[1]); end
      total++; if (q_st[1] !== 1'b1 || q_lv[1] !== 1'b1 || q_per[1] !== 8'd0 || q_hi[1] !== 8'd0) begin
        bad++; $display("FAIL sthigh_vals got st=%b lv=%b per=%0d hi=%0d exp st=1 lv=1 per=0 hi=0",
                        q_st[1], q_lv[1], q_per[1], q_hi[1]);
      end
    end
  endtask

  task automatic test_min_period();
    reset_meas();
    drive_frames(2, 1, 20, 4, 1'b0, 1'b0);
    total++; if (q_idx.size() != 19) begin bad++; $display("FAIL minp_count got=%0d exp=19", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_per[i] !== 8'd2 || q_hi[i] !== 8'd1 || q_idx[i] != 4 + 2*i) begin
        bad++; $display("FAIL minp_vals[%0d] got idx=%0d per=%0d hi=%0d exp %0d/2/1",
                        i, q_idx[i], q_per[i], q_hi[i], 4 + 2*i);
      end
    end
  endtask

  task automatic test_enable_mid();
    reset_meas();
    drive_frames(64, 32, 3, 0, 1'b0, 1'b0);
    repeat (10) cyc(1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      total++;
      if (a_mv !== 1'b0 || a_period !== 8'd64 || a_high !== 8'd32) begin
        bad++; $display("FAIL en_hold[%0d] got mv=%b per=%0d hi=%0d exp 0/64/32", i, a_mv, a_period, a_high);
      end
    end
    enable = 1'b1;
    repeat (17) cyc(1'b1);
    repeat (32) cyc(1'b0);
    drive_frames(64, 32, 2, 0, 1'b0, 1'b0);
    total++; if (q_idx.size() != 1) begin bad++; $display("FAIL en_count got=%0d exp=1", q_idx.size()); end
    if (q_idx.size() == 1) begin
      total++; if (q_idx[0] != 66 || q_per[0] !== 8'd64 || q_hi[0] !== 8'd32) begin
        bad++; $display("FAIL en_resume got idx=%0d per=%0d hi=%0d exp 66/64/32", q_idx[0], q_per[0], q_hi[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_meas();
    drive_frames(64, 32, 2, 0, 1'b0, 1'b0);
    repeat (10) cyc(1'b1);
    total++; if (a_period !== 8'd64 || a_level !== 1'b1) begin
      bad++; $display("FAIL rmid_before got per=%0d lv=%b exp 64/1", a_period, a_level);
    end
    rst_n = 1'b0;
    cyc(1'b1);
    total++;
    if (a_period !== 8'd0 || a_high !== 8'd0 || a_static !== 1'b0 || a_level !== 1'b0 || a_mv !== 1'b0) begin
      bad++; $display("FAIL rmid_zero got per=%0d hi=%0d st=%b lv=%b mv=%b exp all 0",
                      a_period, a_high, a_static, a_level, a_mv);
    end
    rst_n = 1'b1;
    repeat (3) cyc(1'b0);
  endtask

  task automatic test_timeout_boundary();
    reset_meas();
    drive_frames(64, 32, 4, 0, 1'b0, 1'b1);
    total++; if (q_idx.size() != 3) begin bad++; $display("FAIL tob_count got=%0d exp=3", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      total++;
      if (q_per[i] !== 8'd64 || q_hi[i] !== 8'd32 || q_st[i] !== 1'b0) begin
        bad++; $display("FAIL tob_vals[%0d] got per=%0d hi=%0d st=%b exp 64/32/0", i, q_per[i], q_hi[i], q_st[i]);
      end
    end
    drive_frames(65, 32, 2, 0, 1'b0, 1'b1);
    total++; if (q_idx.size() != 2) begin bad++; $display("FAIL tob65_count got=%0d exp=2", q_idx.size()); end
    if (q_idx.size() == 2) begin
      total++; if (q_idx[0] != 2 || q_per[0] !== 8'd64 || q_st[0] !== 1'b0) begin
        bad++; $display("FAIL tob65_last got idx=%0d per=%0d st=%b exp 2/64/0", q_idx[0], q_per[0], q_st[0]);
      end
      total++;
      if (q_idx[1] != 66 || q_st[1] !== 1'b1 || q_per[1] !== 8'd0 || q_hi[1] !== 8'd0 || q_lv[1] !== 1'b0) begin
        bad++; $display("FAIL tob65_static got idx=%0d st=%b per=%0d hi=%0d lv=%b exp 66/1/0/0/0",
                        q_idx[1], q_st[1], q_per[1], q_hi[1], q_lv[1]);
      end
    end
  endtask

  initial begin
    pulse  = 1'b0;
    enable = 1'b1;
    rst_n  = 1'b0;
    test_reset();
    test_static_low();
    test_square_after_static();
    test_duty_extremes();
    test_static_high();
    test_min_period();
    test_enable_mid();
    test_reset_mid();
    test_timeout_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
